multichannel_slew_limiter: RTL and testbench

- Time-multiplexed, multi-channel slew-rate limiter for the discrete audio path.
- Each channel's output tracks its input but may rise by at most RISE_RATE V/s and fall by at most FALL_RATE V/s, each set independently.
- Limiting uses a fractional accumulator, so slew rates below one LSB per sample are honoured.
- One shared add/compare datapath serves all channels in sequence after each audio sample strobe; it sits between a channel's discrete-model output and the mixer.

---
 rtl/multichannel_slew_limiter.sv | 150 +++++++++++++++
 tb/tb_multichannel_slew_limiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multichannel_slew_limiter.sv
// multichannel_slew_limiter
// Time-multiplexed slew-rate limiter for the discrete audio path. One shared
// add/compare datapath walks every channel after each audio sample strobe and
// moves each channel's fractional accumulator toward its input by at most the
// rise or fall step. All outputs then update together in a single cycle.
// Optional feature macro: SLEW_LIMITER_BYPASS_EN adds a per-channel bypass port.
module multichannel_slew_limiter #(
    parameter int WIDTH       = 16,
    parameter int CHANNELS    = 4,
    parameter int FRAC_BITS   = 8,
    parameter int VCC         = 12,
    parameter int SAMPLE_RATE = 48000,
    parameter int RISE_RATE   = 950,
    parameter int FALL_RATE   = 950
) (
    input  logic                      clk,
    input  logic                      I_RSTn,
    input  logic                      audio_clk_en,
    input  logic [CHANNELS*WIDTH-1:0] in,
    output logic [CHANNELS*WIDTH-1:0] out,
    output logic                      out_valid,
    output logic                      busy,
    output logic                      overrun
`ifdef SLEW_LIMITER_BYPASS_EN
    ,
    input  logic [CHANNELS-1:0]       bypass
`endif
);

    localparam int AW = WIDTH + FRAC_BITS;
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    // Step sizes in fractional LSBs per sample; a zero step would freeze the
    // channel forever, so it is bumped to the smallest possible movement.
    localparam longint RISE_RAW  = (longint'(RISE_RATE) << (WIDTH - 2 + FRAC_BITS))
                                   / longint'(VCC) / longint'(SAMPLE_RATE);
    localparam longint FALL_RAW  = (longint'(FALL_RATE) << (WIDTH - 2 + FRAC_BITS))
                                   / longint'(VCC) / longint'(SAMPLE_RATE);
    localparam longint RISE_STEP = (RISE_RAW == 0) ? 64'sd1 : RISE_RAW;
    localparam longint FALL_STEP = (FALL_RAW == 0) ? 64'sd1 : FALL_RAW;

    localparam logic signed [AW:0]   RISE_S   = RISE_STEP[AW:0];
    localparam logic signed [AW:0]   FALL_NEG = -FALL_STEP[AW:0];
    localparam logic        [AW-1:0] RISE_A   = RISE_STEP[AW-1:0];
    localparam logic        [AW-1:0] FALL_A   = FALL_STEP[AW-1:0];
    localparam logic        [CW-1:0] LAST_CH  = CW'(CHANNELS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [CW-1:0]           ch;
    logic signed [WIDTH-1:0] in_l [CHANNELS];
    logic signed [AW-1:0]    acc  [CHANNELS];
`ifdef SLEW_LIMITER_BYPASS_EN
    logic [CHANNELS-1:0]     byp_l;
`endif
    logic                    accept;
    logic                    drop;
    logic                    last_ch;
    logic signed [AW:0]      tgt;
    logic signed [AW:0]      cur;
    logic signed [AW:0]      diff;
    logic [AW-1:0]           nxt;

    // State register plus the channel pointer that walks the RUN slots
    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state <= IDLE;
            ch    <= '0;
        end else begin
            state <= next_state;
            if (state == RUN) ch <= ch + 1'b1;
            else              ch <= '0;
        end
    end

    // Next-state: one RUN slot per channel, then a single DONE cycle
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (audio_clk_en) next_state = RUN;
            RUN:     if (last_ch)      next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Decoded FSM outputs; a strobe arriving mid-pass is dropped, not queued
    always_comb begin
        busy    = (state != IDLE);
        accept  = audio_clk_en && (state == IDLE);
        drop    = audio_clk_en && (state != IDLE);
        last_ch = (ch == LAST_CH);
    end

    // Shared limiter: one extra bit on the difference so it can never wrap
    always_comb begin
        tgt  = {in_l[ch][WIDTH-1], in_l[ch], {FRAC_BITS{1'b0}}};
        cur  = {acc[ch][AW-1], acc[ch]};
        diff = tgt - cur;
        if (diff > RISE_S)        nxt = acc[ch] + RISE_A;
        else if (diff < FALL_NEG) nxt = acc[ch] - FALL_A;
        else                      nxt = tgt[AW-1:0];
`ifdef SLEW_LIMITER_BYPASS_EN
        if (byp_l[ch]) nxt = tgt[AW-1:0];
`endif
    end

    // Input latch at acceptance and per-channel accumulator update in RUN
    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            for (int k = 0; k < CHANNELS; k++) begin
                acc[k]  <= '0;
                in_l[k] <= '0;
            end
`ifdef SLEW_LIMITER_BYPASS_EN
            byp_l <= '0;
`endif
        end else begin
            if (accept) begin
                for (int k = 0; k < CHANNELS; k++) in_l[k] <= in[k*WIDTH +: WIDTH];
`ifdef SLEW_LIMITER_BYPASS_EN
                byp_l <= bypass;
`endif
            end
            if (state == RUN) acc[ch] <= nxt;
        end
    end

    // Coherent output load in DONE, valid pulse and sticky overrun flag
    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            out       <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= (state == DONE);
            if (drop) overrun <= 1'b1;
            if (state == DONE) begin
                for (int k = 0; k < CHANNELS; k++) out[k*WIDTH +: WIDTH] <= acc[k][AW-1:FRAC_BITS];
            end
        end
    end

endmodule

// File: tb/tb_multichannel_slew_limiter.sv
// Testbench for multichannel_slew_limiter: directed scenarios with literal
// expectations plus randomized strobes compared every cycle to a behavioural
// model built from the slew rules and strobe timing arithmetic.
module tb_multichannel_slew_limiter;

    localparam int WIDTH       = 16;
    localparam int CHANNELS    = 4;
    localparam int FRAC_BITS   = 8;
    localparam int VCC         = 12;
    localparam int SAMPLE_RATE = 48000;
    localparam int RISE_RATE   = 950;
    localparam int FALL_RATE   = 1900;

    localparam longint RS_RAW = (longint'(RISE_RATE) * (longint'(1) << (WIDTH - 2 + FRAC_BITS))) / VCC / SAMPLE_RATE;
    localparam longint FS_RAW = (longint'(FALL_RATE) * (longint'(1) << (WIDTH - 2 + FRAC_BITS))) / VCC / SAMPLE_RATE;
    localparam longint RS = (RS_RAW < 1) ? 1 : RS_RAW;
    localparam longint FS = (FS_RAW < 1) ? 1 : FS_RAW;

    logic                      clk = 1'b0;
    logic                      I_RSTn = 1'b0;
    logic                      audio_clk_en = 1'b0;
    logic [CHANNELS*WIDTH-1:0] in_bus = '0;
    logic [CHANNELS*WIDTH-1:0] out;
    logic                      out_valid;
    logic                      busy;
    logic                      overrun;
    logic [CHANNELS-1:0]       bypass = '0;

    int total = 0;
    int bad   = 0;
    int stim [CHANNELS];

    // Behavioural model state
    longint m_acc   [CHANNELS];
    longint pend    [CHANNELS];
    longint exp_out [CHANNELS];
    bit     exp_valid   = 1'b0;
    bit     exp_busy    = 1'b0;
    bit     exp_overrun = 1'b0;
    longint edge_cnt = 0;
    longint acc_edge = -1;
    longint out_edge = -1;
    longint next_ok  = 0;
    bit     chk_en   = 1'b0;

    multichannel_slew_limiter #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .FRAC_BITS(FRAC_BITS), .VCC(VCC),
        .SAMPLE_RATE(SAMPLE_RATE), .RISE_RATE(RISE_RATE), .FALL_RATE(FALL_RATE)
    ) dut (
        .clk(clk),
        .I_RSTn(I_RSTn),
        .audio_clk_en(audio_clk_en),
        .in(in_bus),
        .out(out),
        .out_valid(out_valid),
        .busy(busy),
        .overrun(overrun)
`ifdef SLEW_LIMITER_BYPASS_EN
        ,
        .bypass(bypass)
`endif
    );

    always #5 clk = ~clk;

    // One limiter step for a channel, straight from the slew rules
    function automatic longint stepAcc(input longint a, input longint inv, input bit byp);
        longint t;
        longint d;
        t = inv * (longint'(1) << FRAC_BITS);
        d = t - a;
        if (byp)      return t;
        if (d > RS)   return a + RS;
        if (d < -FS)  return a - FS;
        return t;
    endfunction

    function automatic longint outCh(input int k);
        logic signed [WIDTH-1:0] v;
        v = out[k*WIDTH +: WIDTH];
        return longint'(v);
    endfunction

    function automatic longint inCh(input int k);
        logic signed [WIDTH-1:0] v;
        v = in_bus[k*WIDTH +: WIDTH];
        return longint'(v);
    endfunction

    task automatic checkOutput(input string name, input longint act, input longint expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    initial begin
        for (int k = 0; k < CHANNELS; k++) begin
            m_acc[k] = 0; pend[k] = 0; exp_out[k] = 0; stim[k] = 0;
        end
    end

    // Model reset: any in-flight pass is forgotten
    always @(negedge I_RSTn) begin
        for (int k = 0; k < CHANNELS; k++) begin
            m_acc[k] = 0; pend[k] = 0; exp_out[k] = 0;
        end
        exp_valid = 0; exp_busy = 0; exp_overrun = 0;
        edge_cnt = 0; acc_edge = -1; out_edge = -1; next_ok = 0;
    end

    // Model advance: acceptance by strobe spacing, output after CHANNELS+1 edges
    always @(posedge clk) begin
        if (I_RSTn) begin
            edge_cnt++;
            if (audio_clk_en) begin
                if (edge_cnt >= next_ok) begin
                    acc_edge = edge_cnt;
                    out_edge = edge_cnt + CHANNELS + 1;
                    next_ok  = edge_cnt + CHANNELS + 2;
                    for (int k = 0; k < CHANNELS; k++) begin
                        m_acc[k] = stepAcc(m_acc[k], inCh(k), bypass[k]);
                        pend[k]  = m_acc[k] >>> FRAC_BITS;
                    end
                end else begin
                    exp_overrun = 1'b1;
                end
            end
            exp_valid = (edge_cnt == out_edge);
            if (exp_valid) for (int k = 0; k < CHANNELS; k++) exp_out[k] = pend[k];
            exp_busy = (acc_edge >= 0) && (edge_cnt >= acc_edge) && (edge_cnt <= acc_edge + CHANNELS);
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en && I_RSTn) begin
            for (int k = 0; k < CHANNELS; k++)
                checkOutput($sformatf("model_out_ch%0d", k), outCh(k), exp_out[k]);
            checkOutput("model_out_valid", longint'(out_valid), longint'(exp_valid));
            checkOutput("model_busy", longint'(busy), longint'(exp_busy));
            checkOutput("model_overrun", longint'(overrun), longint'(exp_overrun));
        end
    end

    task automatic driveInputs();
        for (int k = 0; k < CHANNELS; k++) in_bus[k*WIDTH +: WIDTH] = WIDTH'(stim[k]);
    endtask

    // Strobe with the current stim values; next strobe comes 'spacing' clocks later
    task automatic applyStimulus(input int spacing);
        @(negedge clk);
        driveInputs();
        audio_clk_en = 1'b1;
        @(negedge clk);
        audio_clk_en = 1'b0;
        repeat (spacing - 2) @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        #2 I_RSTn = 1'b0;
        @(negedge clk);
        #2 I_RSTn = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #2 I_RSTn = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        checkOutput("reset_out_ch0", outCh(0), 0);
        checkOutput("reset_busy", longint'(busy), 0);
        checkOutput("reset_out_valid", longint'(out_valid), 0);
        checkOutput("reset_overrun", longint'(overrun), 0);

        // Step up on channel 0
        stim = '{1000, 0, 0, 0};
        applyStimulus(10);
        checkOutput("stepup_1", outCh(0), 27);
        applyStimulus(10);
        checkOutput("stepup_2", outCh(0), 54);
        applyStimulus(10);
        checkOutput("stepup_3", outCh(0), 81);
        repeat (37) applyStimulus(10);
        checkOutput("stepup_final", outCh(0), 1000);
        checkOutput("stepup_ch1_idle", outCh(1), 0);

        // Step down on channel 1
        stim = '{1000, 1000, 0, 0};
        repeat (40) applyStimulus(10);
        checkOutput("stepdown_settled", outCh(1), 1000);
        stim[1] = 0;
        applyStimulus(10);
        checkOutput("stepdown_1", outCh(1), 945);
        applyStimulus(10);
        checkOutput("stepdown_2", outCh(1), 891);
        repeat (20) applyStimulus(10);
        checkOutput("stepdown_final", outCh(1), 0);

        // Latency and coherence with small deltas; late input change ignored
        stim = '{1005, -5, 5, -5};
        @(negedge clk);
        driveInputs();
        audio_clk_en = 1'b1;
        @(negedge clk);
        audio_clk_en = 1'b0;
        for (int i = 0; i <= 6; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 2) in_bus[WIDTH-1:0] = WIDTH'(3000);
            checkOutput($sformatf("lat_busy_%0d", i), longint'(busy), (i <= CHANNELS) ? 1 : 0);
            checkOutput($sformatf("lat_valid_%0d", i), longint'(out_valid), (i == CHANNELS + 1) ? 1 : 0);
            checkOutput($sformatf("lat_ch0_%0d", i), outCh(0), (i >= CHANNELS + 1) ? 1005 : 1000);
            checkOutput($sformatf("lat_ch3_%0d", i), outCh(3), (i >= CHANNELS + 1) ? -5 : 0);
        end
        checkOutput("lat_ch1", outCh(1), -5);
        checkOutput("lat_ch2", outCh(2), 5);

        // Overrun: second strobe three clocks after the first is dropped
        checkOutput("overrun_before", longint'(overrun), 0);
        stim = '{1000, 0, 0, 0};
        @(negedge clk);
        driveInputs();
        audio_clk_en = 1'b1;
        @(negedge clk);
        audio_clk_en = 1'b0;
        repeat (2) @(negedge clk);
        in_bus[WIDTH-1:0] = WIDTH'(4000);
        audio_clk_en = 1'b1;
        @(negedge clk);
        audio_clk_en = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("overrun_set", longint'(overrun), 1);
        checkOutput("overrun_out_ch0", outCh(0), 1000);
        checkOutput("overrun_out_ch1", outCh(1), 0);
        applyStimulus(10);
        checkOutput("overrun_sticky", longint'(overrun), 1);

        // Asynchronous reset in the middle of a pass
        stim = '{3000, 200, 0, 0};
        @(negedge clk);
        driveInputs();
        audio_clk_en = 1'b1;
        @(negedge clk);
        audio_clk_en = 1'b0;
        repeat (2) @(negedge clk);
        #2 I_RSTn = 1'b0;
        #1;
        checkOutput("rst_out_ch0", outCh(0), 0);
        checkOutput("rst_busy", longint'(busy), 0);
        checkOutput("rst_out_valid", longint'(out_valid), 0);
        checkOutput("rst_overrun", longint'(overrun), 0);
        @(negedge clk);
        #2 I_RSTn = 1'b1;
        stim = '{1000, 0, 0, 0};
        applyStimulus(10);
        checkOutput("rst_restart_ch0", outCh(0), 27);

`ifdef SLEW_LIMITER_BYPASS_EN
        doReset();
        stim = '{1000, 1000, 0, 0};
        bypass = 4'b0001;
        applyStimulus(10);
        checkOutput("bypass_ch0", outCh(0), 1000);
        checkOutput("bypass_ch1", outCh(1), 27);
        bypass = '0;
`endif

        // Randomized strobes and spacings, including overruns
        doReset();
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < CHANNELS; k++) begin
                logic signed [WIDTH-1:0] r;
                r = WIDTH'($urandom);
                if ($urandom_range(0, 3) == 0) stim[k] = stim[k] + int'($urandom_range(0, 20)) - 10;
                else                           stim[k] = int'(r);
                if (stim[k] > 32767)  stim[k] = 32767;
                if (stim[k] < -32768) stim[k] = -32768;
            end
`ifdef SLEW_LIMITER_BYPASS_EN
            bypass = CHANNELS'($urandom);
`endif
            applyStimulus(int'($urandom_range(2, 12)));
        end
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
